// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_e;
    typedef enum logic {REQ_IF, REQ_LS} req_id_e;

    localparam int MEM_LATENCY_MAX = 7;
    // Latency counter must hold values up to MEM_LATENCY_MAX.
    localparam int CNT_W = $clog2(MEM_LATENCY_MAX + 1);

    // Pick a winner between the two requesters. A lone requester always wins.
    // On contention, round-robin favours whoever did not win last; fixed
    // priority always favours LS.
    function automatic req_id_e pick_winner(
        input logic    if_req,
        input logic    ls_req,
        input req_id_e last,
        input logic    rr_mode
    );
        req_id_e win;
        if (if_req && !ls_req) begin
            win = REQ_IF;
        end else if (ls_req && !if_req) begin
            win = REQ_LS;
        end else if (rr_mode) begin
            win = (last == REQ_LS) ? REQ_IF : REQ_LS;
        end else begin
            win = REQ_LS;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way picker for IF/LS. Holds the last winner for round-robin fairness.
module rr_arbiter2
    import mem_arbiter_pkg::*;
#(
    parameter int RR_MODE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_if,
    input  logic req_ls,
    output logic gnt_if,
    output logic gnt_ls
);

    req_id_e rr_last_q;
    req_id_e rr_last_d;
    req_id_e win;

    // Grant only when the owner says a new access may start; remember the winner.
    always_comb begin
        gnt_if    = 1'b0;
        gnt_ls    = 1'b0;
        rr_last_d = rr_last_q;
        win       = pick_winner(req_if, req_ls, rr_last_q, (RR_MODE != 0));
        if (en && (req_if || req_ls)) begin
            if (win == REQ_IF) begin
                gnt_if    = 1'b1;
                rr_last_d = REQ_IF;
            end else begin
                gnt_ls    = 1'b1;
                rr_last_d = REQ_LS;
            end
        end
    end

    // Reset to LS so IF wins the first contended request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= REQ_LS;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (LS).
// One access in flight; the response returns a fixed MEM_LATENCY cycles after grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,   // 1..MEM_LATENCY_MAX
    parameter int RR_MODE     = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_id_e          win_q, win_d;
    logic             store_q, store_d;

    logic arb_en;
    logic gnt_if, gnt_ls;
    logic resp_cyc;

    // New accesses may only start from IDLE; reset suppresses any grant.
    assign arb_en   = (state_q == ARB_IDLE) && !reset;
    // Response cycle: the counter has run down to its last step.
    assign resp_cyc = (state_q == ARB_BUSY) && (cnt_q == CNT_W'(1)) && !reset;

    rr_arbiter2 #(
        .RR_MODE (RR_MODE)
    ) u_rr (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .req_if (if_req),
        .req_ls (ls_req),
        .gnt_if (gnt_if),
        .gnt_ls (gnt_ls)
    );

    // State register: reset aborts any in-flight access without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            win_q   <= REQ_LS;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            store_q <= store_d;
        end
    end

    // Next state: latch the winner on grant, count down while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        store_d = store_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_if || gnt_ls) begin
                    state_d = ARB_BUSY;
                    cnt_d   = CNT_W'(MEM_LATENCY);
                    win_d   = gnt_ls ? REQ_LS : REQ_IF;
                    store_d = gnt_ls && ls_we;
                end
            end
            ARB_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: drive the memory from the winner in the grant cycle, and
    // route the response to the stored winner in the response cycle.
    always_comb begin
        if_gnt    = gnt_if;
        ls_gnt    = gnt_ls;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (gnt_ls) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_be    = ls_be;
            mem_wdata = ls_wdata;
        end else if (gnt_if) begin
            // Fetches are always full-word reads.
            mem_req   = 1'b1;
            mem_addr  = if_addr;
            mem_be    = {BE_W{1'b1}};
        end
        if (resp_cyc) begin
            if (win_q == REQ_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                ls_rvalid = 1'b1;
                // Stores return an acknowledge only, never stale read data.
                ls_rdata  = store_q ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (L=1 RR, L=2 RR, L=3 fixed).
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_be;

    logic        ig_a [3], iv_a [3], lg_a [3], lv_a [3], mr_a [3], mw_a [3];
    logic [31:0] ird_a [3], lrd_a [3], ma_a [3], mwd_a [3];
    logic [3:0]  mb_a [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] rdata;
        logic [31:0] last_addr = 32'h0;
        mem_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LATENCY (g == 0 ? 1 : (g == 1 ? 2 : 3)),
            .RR_MODE     (g == 2 ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (ig_a[g]),
            .if_rvalid (iv_a[g]),
            .if_rdata  (ird_a[g]),
            .ls_req    (ls_req),
            .ls_we     (ls_we),
            .ls_addr   (ls_addr),
            .ls_be     (ls_be),
            .ls_wdata  (ls_wdata),
            .ls_gnt    (lg_a[g]),
            .ls_rvalid (lv_a[g]),
            .ls_rdata  (lrd_a[g]),
            .mem_req   (mr_a[g]),
            .mem_we    (mw_a[g]),
            .mem_addr  (ma_a[g]),
            .mem_be    (mb_a[g]),
            .mem_wdata (mwd_a[g]),
            .mem_rdata (rdata)
        );
        // Memory model: read data = last strobed address + 3, held until next strobe.
        always @(posedge clk) if (mr_a[g]) last_addr <= ma_a[g];
        assign rdata = last_addr + 32'd3;
    end

    typedef struct {
        logic rst; logic ifr; logic [31:0] ifa;
        logic lsr; logic we; logic [31:0] lsa; logic [3:0] be; logic [31:0] wd;
        logic ig; logic iv; logic [31:0] ird;
        logic lg; logic lv; logic [31:0] lrd;
        logic mr; logic mw; logic [31:0] ma; logic [3:0] mb; logic [31:0] mwd;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [137:0] obs(input int g);
        return {ig_a[g], iv_a[g], ird_a[g], lg_a[g], lv_a[g], lrd_a[g],
                mr_a[g], mw_a[g], ma_a[g], mb_a[g], mwd_a[g]};
    endfunction

    task automatic chk(input string nm, input logic [137:0] got, input logic [137:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic drv(input logic r, input logic ifr, input logic [31:0] ifa,
                       input logic lsr, input logic we, input logic [31:0] lsa,
                       input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset = r; if_req = ifr; if_addr = ifa;
        ls_req = lsr; ls_we = we; ls_addr = lsa; ls_be = be; ls_wdata = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_be = '0; ls_wdata = '0;

        // Table for instance 0 (MEM_LATENCY=1, round-robin).
        //          rst   ifr   ifa         lsr   we    lsa         be    wd            ig    iv    ird         lg    lv    lrd         mr    mw    ma          mb    mwd
        tbl[0]  = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h10,     1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h10,     4'hF, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h14,     1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b1, 32'h13,     1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h14,     1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h14,     4'hF, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b1, 32'h17,     1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h100,    4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 32'h100,    4'h3, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h200,    4'hF, 32'h0,        1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h200,    4'hF, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 32'h203,    1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h20,     1'b1, 1'b0, 32'h300,    4'hF, 32'h0,        1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h20,     4'hF, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 32'h24,     1'b1, 1'b0, 32'h300,    4'hF, 32'h0,        1'b0, 1'b1, 32'h23,     1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 32'h24,     1'b1, 1'b0, 32'h300,    4'hF, 32'h0,        1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h300,    4'hF, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 32'h24,     1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 32'h303,    1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 32'h24,     1'b0, 1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      4'h0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            drv(tbl[i].rst, tbl[i].ifr, tbl[i].ifa, tbl[i].lsr, tbl[i].we,
                tbl[i].lsa, tbl[i].be, tbl[i].wd);
            chk($sformatf("vec%0d", i), obs(0),
                {tbl[i].ig, tbl[i].iv, tbl[i].ird, tbl[i].lg, tbl[i].lv, tbl[i].lrd,
                 tbl[i].mr, tbl[i].mw, tbl[i].ma, tbl[i].mb, tbl[i].mwd});
        end

        // Round-robin, L=2, both held: IF, LS, IF, LS with rvalid two cycles later.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            logic eig, elg, eiv, elv;
            eig = (k % 3 == 0) && ((k / 3) % 2 == 0);
            elg = (k % 3 == 0) && ((k / 3) % 2 == 1);
            eiv = (k % 3 == 2) && ((k / 3) % 2 == 0);
            elv = (k % 3 == 2) && ((k / 3) % 2 == 1);
            drv(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
            chk($sformatf("rr k%0d", k),
                138'({ig_a[1], lg_a[1], iv_a[1], lv_a[1], ird_a[1], lrd_a[1]}),
                138'({eig, elg, eiv, elv, (eiv ? 32'h43 : 32'h0), (elv ? 32'h83 : 32'h0)}));
        end

        // Fixed priority, L=3: LS wins every time; IF only once ls_req drops.
        do_reset();
        for (int k = 0; k < 13; k++) begin
            logic elg, elv, eig;
            elg = (k < 12) && (k % 4 == 0);
            elv = (k < 12) && (k % 4 == 3);
            eig = (k == 12);
            drv(1'b0, 1'b1, 32'h50, (k < 12), 1'b0, 32'hA0, 4'hF, 32'h0);
            chk($sformatf("fix k%0d", k),
                138'({ig_a[2], lg_a[2], iv_a[2], lv_a[2]}),
                138'({eig, elg, 1'b0, elv}));
        end

        // Reset one cycle after a load grant (L=3): transaction is dropped.
        do_reset();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
        chk("abort grant", 138'(lg_a[2]), 138'(1'b1));
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("abort rst lv", 138'(lv_a[2]), 138'(1'b0));
        idle();
        chk("abort outs zero", obs(2), 138'(0));
        drv(1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("abort new if", 138'({ig_a[2], mr_a[2], ma_a[2], lv_a[2]}),
            138'({1'b1, 1'b1, 32'h60, 1'b0}));
        idle();
        chk("abort k4", 138'({lv_a[2], iv_a[2]}), 138'(0));
        idle();
        chk("abort k5", 138'({lv_a[2], iv_a[2]}), 138'(0));
        idle();
        chk("abort if resp", 138'({iv_a[2], ird_a[2], lv_a[2]}),
            138'({1'b1, 32'h63, 1'b0}));

        // ls_req rises while IF is in flight (L=2): LS waits for the next IDLE cycle.
        do_reset();
        drv(1'b0, 1'b1, 32'h70, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("busy k0", 138'({ig_a[1], lg_a[1]}), 138'({1'b1, 1'b0}));
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 4'hF, 32'h12345678);
        chk("busy k1", 138'({ig_a[1], lg_a[1], iv_a[1]}), 138'(0));
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 4'hF, 32'h12345678);
        chk("busy k2", 138'({ig_a[1], lg_a[1], iv_a[1], ird_a[1]}),
            138'({1'b0, 1'b0, 1'b1, 32'h73}));
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 4'hF, 32'h12345678);
        chk("busy k3", 138'({ig_a[1], lg_a[1], mw_a[1], ma_a[1], mwd_a[1]}),
            138'({1'b0, 1'b1, 1'b1, 32'h90, 32'h12345678}));
        idle();
        chk("busy k4", 138'({lv_a[1], iv_a[1]}), 138'(0));
        idle();
        chk("busy k5", 138'({lv_a[1], lrd_a[1]}), 138'({1'b1, 32'h0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF) and the load/store requester (LS) of the RISC-V core.
- Sits between the core's fetch/data paths and the memory macro.
- One transaction outstanding at a time, with a request/grant/response handshake per requester.
- Configurable arbitration policy and fixed memory read latency.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from mem_req to mem_rdata valid (range 1..7).
- RR_MODE, 1, arbitration policy: 1 = round-robin, 0 = fixed priority with LS over IF.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  if_rdata valid; one-cycle pulse.
- if_rdata  out  DATA_W  fetched instruction.
- ls_req  in  1  LS request; held with its payload until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  LS address.
- ls_be  in  DATA_W/8  byte enables for stores.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  LS request accepted this cycle.
- ls_rvalid  out  1  load data valid or store acknowledged; one-cycle pulse.
- ls_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_req.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - FSM = IDLE, latency counter = 0, rr_last = LS (so IF wins the first contended request after reset).
  - All gnt, rvalid and mem_* outputs = 0; rdata outputs = 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any req is high, select a winner. gnt[winner] = 1 combinationally in the same cycle.
  - In that cycle, drive mem_req = 1 and mem_we/addr/be/wdata from the winner. IF is always a read with be = all-ones.
  - Register the winner ID and load counter = MEM_LATENCY, then go to BUSY.
  - If no req is high, all strobes stay 0.
- Arbitration:
  - RR_MODE = 1: when both requesters are pending, grant the one not in rr_last. Update rr_last on every grant.
  - RR_MODE = 0: LS always beats IF.
  - A single pending requester wins regardless of policy.
- BUSY:
  - Counter decrements each cycle. gnt = 0 and mem_req = 0.
  - When counter reaches 1, assert rvalid for the stored winner that cycle. rdata = mem_rdata for loads/fetches, 0 for stores.
  - Return to IDLE next cycle.
  - Earliest next grant is the cycle after rvalid, so throughput is one access per MEM_LATENCY+1 cycles.
- Requests that arrive while BUSY are held by the requester and not granted until IDLE.
- At most one gnt per cycle. The gnt pulse and the matching rvalid pulse are exactly MEM_LATENCY cycles apart.
- rvalid never asserts for the requester that did not win.
- Reset mid-operation (BUSY):
  - Aborts the transaction: no rvalid is issued and the FSM returns to IDLE.
  - The memory write already strobed is not undone.
- Deasserting req before gnt withdraws the request. This is legal only in IDLE with no grant that cycle.
- Address passes through unmodified. Alignment checks belong to the core.

Decomposition:
- Shared package riscv_pkg adds:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_e.
  - typedef enum logic {REQ_IF, REQ_LS} req_id_e.
  - constant MEM_LATENCY_MAX = 7.
- A natural sub-module is rr_arbiter2: 2-way round-robin/fixed-priority picker holding rr_last. The mem_arbiter top holds the FSM, counter and muxing.

Test Plan:
- IF only, MEM_LATENCY=1, if_addr=0x0000_0010, mem_rdata=0x0000_0013:
  - if_gnt and mem_req at cycle t.
  - if_rvalid at t+1 with if_rdata=0x0000_0013.
  - Next grant no earlier than t+2.
- Store, LS only: ls_we=1, addr=0x100, be=4'b0011, wdata=0xDEADBEEF:
  - mem_we=1 with the same address, be and wdata in the grant cycle.
  - ls_rvalid after MEM_LATENCY cycles with ls_rdata=0.
- RR_MODE=1, both requesters held for 4 transactions, MEM_LATENCY=2:
  - Grant order is IF, LS, IF, LS.
  - Each rvalid arrives 2 cycles after its gnt, on the correct port only.
- RR_MODE=0, both requesters held:
  - LS granted every transaction.
  - IF granted only once ls_req drops.
- Reset asserted in BUSY one cycle after a load grant (MEM_LATENCY=3):
  - No ls_rvalid.
  - All outputs 0 the cycle after reset.
  - A new IF request after reset is granted immediately.
- ls_req rises during BUSY:
  - No ls_gnt until the cycle after the in-flight if_rvalid.
  - No two gnts in the same cycle.
